// File: rtl/sampler_packetizer.sv
// Frames sampler FIFO words into packets: {MAGIC,SEQ} header, PAYLOAD_WORDS data words, XOR-checksum trailer.
// Latency: header one cycle after IDLE sees data, then one output word per cycle when unstalled.
// Backpressure: OUT_FULL stalls header, payload and trailer. IN_EMPTY stalls payload. Stalls are held indefinitely.
module sampler_packetizer #(
  parameter int          PAYLOAD_WORDS = 16,
  parameter logic [15:0] MAGIC         = 16'hA55A
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ENABLE,
  input  logic [31:0] IN_DATA,
  input  logic        IN_EMPTY,
  output logic        IN_RDEN,
  output logic [31:0] OUT_DATA,
  output logic        OUT_WREN,
  input  logic        OUT_FULL,
  output logic        BUSY,
  output logic [15:0] SEQ
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_HEADER  = 2'd1;
  localparam logic [1:0] ST_PAYLOAD = 2'd2;
  localparam logic [1:0] ST_TRAILER = 2'd3;

  // Counter value of the final payload word of a packet
  localparam logic [15:0] LAST_CNT = 16'(PAYLOAD_WORDS - 1);

  logic [1:0]  state_q;
  logic [15:0] cnt_q;
  logic [31:0] csum_q;
  logic [15:0] seq_q;

  logic hdr_wr;
  logic xfer;
  logic trl_wr;

  // Write/pop strobes are purely combinational so a word moves in the same cycle it is offered
  always_comb begin
    hdr_wr   = (state_q == ST_HEADER)  && !OUT_FULL;
    xfer     = (state_q == ST_PAYLOAD) && !OUT_FULL && !IN_EMPTY;
    trl_wr   = (state_q == ST_TRAILER) && !OUT_FULL;
    IN_RDEN  = xfer;
    OUT_WREN = hdr_wr || xfer || trl_wr;
    OUT_DATA = 32'd0;
    if (hdr_wr) begin
      OUT_DATA = {MAGIC, seq_q};
    end else if (xfer) begin
      OUT_DATA = IN_DATA;
    end else if (trl_wr) begin
      OUT_DATA = csum_q;
    end
  end

  // Packet framing FSM with payload counter, running checksum and sequence number
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= 16'd0;
      csum_q  <= 32'd0;
      seq_q   <= 16'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // ENABLE only gates the start of a packet, never aborts one
          if (ENABLE && !IN_EMPTY) begin
            state_q <= ST_HEADER;
          end
        end
        ST_HEADER: begin
          if (!OUT_FULL) begin
            cnt_q   <= 16'd0;
            csum_q  <= 32'd0;
            state_q <= ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (xfer) begin
            csum_q <= csum_q ^ IN_DATA;
            cnt_q  <= cnt_q + 16'd1;
            if (cnt_q == LAST_CNT) begin
              state_q <= ST_TRAILER;
            end
          end
        end
        ST_TRAILER: begin
          if (!OUT_FULL) begin
            seq_q   <= seq_q + 16'd1;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign BUSY = (state_q != ST_IDLE);
  assign SEQ  = seq_q;

endmodule
